// File: rtl/eater_ctrl_pkg.sv
// Shared control-word bit map and opcode encoding for the microcoded CPU control path.
package eater_ctrl_pkg;

  localparam int CW_END      = 15;
  localparam int CW_PC_JMP   = 14;
  localparam int CW_PC_OUT   = 13;
  localparam int CW_PC_COUNT = 12;
  localparam int CW_OUT_EN   = 11;
  localparam int CW_B_WR     = 10;
  localparam int CW_ALU_SU   = 9;
  localparam int CW_ALU_EN   = 8;
  localparam int CW_A_EN     = 7;
  localparam int CW_A_WR     = 6;
  localparam int CW_IR_EN    = 5;
  localparam int CW_IR_WR    = 4;
  localparam int CW_RAM_EN   = 3;
  localparam int CW_RAM_WR   = 2;
  localparam int CW_MAR_WR   = 1;
  localparam int CW_HLT      = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_STA  = 4'h4,
    OP_LDI  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_ADDI = 4'h9,
    OP_SUBI = 4'hA,
    OP_CMP  = 4'hB,
    OP_CMPI = 4'hC,
    OP_JNZ  = 4'hD,
    OP_OUT  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_t;

endpackage

// File: rtl/flags_reg.sv
// Two-bit carry/zero flags register, loaded only on qualified ALU steps.
module flags_reg
  import eater_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_q;

  // Load on enable, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 2'b00;
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/step_sequencer.sv
// T-state sequencer: steps the microcode ROM index, owns run/halt/single-step
// control and the carry/zero flags, and counts retired instructions.
module step_sequencer
  import eater_ctrl_pkg::*;
#(
  parameter int MAX_STEP = 4,
  parameter int STEP_W   = 3,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        control_word,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               run,
  input  logic               step_req,
  output logic [STEP_W-1:0]  state,
  output logic               carry_flag,
  output logic               zero_flag,
  output logic               exec_en,
  output logic               halted,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count
);

  logic [STEP_W-1:0]  r_state;
  logic               r_halted;
  logic               r_instr_done;
  logic [COUNT_W-1:0] r_instr_count;
  logic               w_exec_en;
  logic               w_cw_end;
  logic               w_cw_hlt;
  logic               w_flags_en;
  logic [1:0]         w_flags_q;
  logic               w_unused_cw;

  assign w_exec_en  = ~r_halted & (run | step_req);
  assign w_cw_end   = control_word[CW_END];
  assign w_cw_hlt   = control_word[CW_HLT];
  assign w_flags_en = w_exec_en & control_word[CW_ALU_EN];
  // Remaining control-word bits drive the datapath, not this block
  assign w_unused_cw = ^{control_word[14:9], control_word[7:1]};

  // Step counter, halt latch and retire bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= {STEP_W{1'b0}};
      r_halted      <= 1'b0;
      r_instr_done  <= 1'b0;
      r_instr_count <= {COUNT_W{1'b0}};
    end else if (w_exec_en) begin
      if (w_cw_hlt) begin
        r_halted     <= 1'b1;
        r_instr_done <= 1'b0;
      end else if (w_cw_end || (r_state == STEP_W'(MAX_STEP))) begin
        r_state       <= {STEP_W{1'b0}};
        r_instr_done  <= 1'b1;
        r_instr_count <= r_instr_count + COUNT_W'(1);
      end else begin
        r_state      <= r_state + STEP_W'(1);
        r_instr_done <= 1'b0;
      end
    end else begin
      r_instr_done <= 1'b0;
    end
  end

  flags_reg u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_flags_en),
    .i_d   ({alu_carry, alu_zero}),
    .o_q   (w_flags_q)
  );

  assign state       = r_state;
  assign carry_flag  = w_flags_q[1];
  assign zero_flag   = w_flags_q[0];
  assign exec_en     = w_exec_en;
  assign halted      = r_halted;
  assign instr_done  = r_instr_done;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed-vector bench for step_sequencer: stimulus pushes hand-computed
// post-edge expectations into a queue, a monitor pops and compares them.
module tb_step_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] control_word;
  logic        alu_carry;
  logic        alu_zero;
  logic        run;
  logic        step_req;
  logic [2:0]  state;
  logic        carry_flag;
  logic        zero_flag;
  logic        exec_en;
  logic        halted;
  logic        instr_done;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [2:0]  st;
    logic        c;
    logic        z;
    logic        h;
    logic        d;
    logic [15:0] n;
    logic        en;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  step_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .control_word (control_word),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .run          (run),
    .step_req     (step_req),
    .state        (state),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .exec_en      (exec_en),
    .halted       (halted),
    .instr_done   (instr_done),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per clock, sampled just after the rising edge
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state, c: carry_flag, z: zero_flag, h: halted, d: instr_done,
            n: instr_count, en: exec_en};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_check #%0d: got st=%0d c=%b z=%b h=%b d=%b n=%0d en=%b, want st=%0d c=%b z=%b h=%b d=%b n=%0d en=%b",
                 checks, a.st, a.c, a.z, a.h, a.d, a.n, a.en,
                 e.st, e.c, e.z, e.h, e.d, e.n, e.en);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge
  task automatic cyc(input logic r, input logic rn, input logic sp, input logic [15:0] cw,
                     input logic ac, input logic az,
                     input int est, input logic ec, input logic ez, input logic eh,
                     input logic ed, input int en_cnt, input logic een);
    obs_t e;
    @(negedge clk);
    rst_n        = r;
    run          = rn;
    step_req     = sp;
    control_word = cw;
    alu_carry    = ac;
    alu_zero     = az;
    e = '{st: est[2:0], c: ec, z: ez, h: eh, d: ed, n: en_cnt[15:0], en: een};
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step_req = 1'b0;
    control_word = 16'h0000; alu_carry = 1'b0; alu_zero = 1'b0;

    // Reset
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // LDA: T0..T3, END at T3
    cyc(1'b1, 1'b1, 1'b0, 16'h2002, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h1030, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0022, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h8048, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);

    // ADD: ALU inputs toggled early without ALU_EN, flags load only at T4
    cyc(1'b1, 1'b1, 1'b0, 16'h2002, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h1030, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0022, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0408, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h8140, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1);

    // LDI (3 steps): flags hold
    cyc(1'b1, 1'b1, 1'b0, 16'h2002, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h1030, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h8042, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1);

    // Single-step: idle cycles carry ALU_EN but must not touch flags or state
    cyc(1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h2002, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h1030, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    // run and step_req together: one advance only
    cyc(1'b1, 1'b1, 1'b1, 16'h0408, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b1);

    // HLT with END at T2: halt wins, state frozen at 2
    cyc(1'b1, 1'b1, 1'b0, 16'h2002, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h1030, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // END never set: MAX_STEP guard wraps after T4
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);

    // Reset mid-instruction at T3 with carry set
    cyc(1'b1, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
